// File: rtl/syscall_uart_bridge.sv
// syscall_uart_bridge: turns syscall requests (print char, print float, exit)
// into 8N1 UART byte sequences on io_txd. Exit latches its argument and,
// once fully transmitted, raises a sticky io_exit that blocks further requests.
//
// Request handshake: a request transfers on a rising clock edge where
// io_req_valid and io_req_ready are both 1; io_req_code/io_req_arg are
// captured at that edge. While io_req_ready is 0 the request inputs are
// ignored, so the requester may drop valid or change the payload freely.
module syscall_uart_bridge #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [7:0]  io_req_code,
  input  logic [31:0] io_req_arg,
  output logic        io_txd,
  output logic        io_busy,
  output logic        io_exit,
  output logic [31:0] io_exit_code,
  output logic [1:0]  io_dbg_state
);

  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  localparam logic [7:0] CODE_EXIT  = 8'h01;
  localparam logic [7:0] CODE_CHAR  = 8'h03;
  localparam logic [7:0] CODE_FLOAT = 8'h04;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] baud_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [2:0]    byte_cnt_q;
  logic [2:0]    byte_last_q;   // index of the final byte (N-1)
  logic [39:0]   payload_q;     // bytes still to send, current byte in [7:0]
  logic          is_exit_q;
  logic          txd_q;
  logic          exit_q;
  logic [31:0]   exit_code_q;

  logic          accept;
  logic [2:0]    nxt_bit_idx;
  logic [7:0]    cur_byte;

  assign io_req_ready = (state_q == IDLE) && !exit_q;
  assign accept       = io_req_valid && io_req_ready;
  assign cur_byte     = payload_q[7:0];
  assign nxt_bit_idx  = bit_cnt_q + 3'd1;

  assign io_txd       = txd_q;
  assign io_busy      = (state_q != IDLE);
  assign io_exit      = exit_q;
  assign io_exit_code = exit_code_q;
  assign io_dbg_state = state_q;

  // Frame sequencer: accepts requests, paces bits with the baud counter and
  // walks through the bytes of the request with txd registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      byte_last_q <= '0;
      payload_q   <= '0;
      is_exit_q   <= 1'b0;
      txd_q       <= 1'b1;
      exit_q      <= 1'b0;
      exit_code_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q      <= 1'b1;
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          byte_cnt_q <= '0;
          if (accept) begin
            // Unknown codes fall through: accepted and dropped in IDLE.
            case (io_req_code)
              CODE_CHAR: begin
                payload_q   <= {32'h0, io_req_arg[7:0]};
                byte_last_q <= 3'd0;
                is_exit_q   <= 1'b0;
                txd_q       <= 1'b0;
                state_q     <= START;
              end
              CODE_FLOAT: begin
                payload_q   <= {io_req_arg, 8'hF4};
                byte_last_q <= 3'd4;
                is_exit_q   <= 1'b0;
                txd_q       <= 1'b0;
                state_q     <= START;
              end
              CODE_EXIT: begin
                payload_q   <= {io_req_arg, 8'hE1};
                byte_last_q <= 3'd4;
                is_exit_q   <= 1'b1;
                exit_code_q <= io_req_arg;
                txd_q       <= 1'b0;
                state_q     <= START;
              end
              default: ;
            endcase
          end
        end
        START: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            txd_q      <= cur_byte[0];
            state_q    <= DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              txd_q     <= 1'b1;
              state_q   <= STOP;
            end else begin
              bit_cnt_q <= nxt_bit_idx;
              txd_q     <= cur_byte[nxt_bit_idx];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            if (byte_cnt_q == byte_last_q) begin
              byte_cnt_q <= '0;
              txd_q      <= 1'b1;
              state_q    <= IDLE;
              if (is_exit_q) exit_q <= 1'b1;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              byte_cnt_q <= byte_cnt_q + 3'd1;
              payload_q  <= {8'h00, payload_q[39:8]};
              txd_q      <= 1'b0;
              state_q    <= START;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_uart_bridge.sv
// Directed bench for syscall_uart_bridge. Runs with a reduced clock/baud pair
// (100000 / 9600 -> DIV = 10, truncated) so every scenario stays short.
module tb_syscall_uart_bridge;

  localparam int DIV = 10;

  logic        clock;
  logic        reset;
  logic        io_req_valid;
  logic        io_req_ready;
  logic [7:0]  io_req_code;
  logic [31:0] io_req_arg;
  logic        io_txd;
  logic        io_busy;
  logic        io_exit;
  logic [31:0] io_exit_code;
  logic [1:0]  io_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  syscall_uart_bridge #(
    .CLOCK_FREQ(100_000),
    .BAUD_RATE (9_600)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .io_req_valid(io_req_valid),
    .io_req_ready(io_req_ready),
    .io_req_code (io_req_code),
    .io_req_arg  (io_req_arg),
    .io_txd      (io_txd),
    .io_busy     (io_busy),
    .io_exit     (io_exit),
    .io_exit_code(io_exit_code),
    .io_dbg_state(io_dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance one clock; outputs are read and inputs driven 1 time unit later
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: present one request for a single accept edge
  task automatic send(input logic [7:0] code, input logic [31:0] arg);
    io_req_valid = 1'b1;
    io_req_code  = code;
    io_req_arg   = arg;
    chk("ready_before_send", {31'h0, io_req_ready}, 32'h1);
    step();
    io_req_valid = 1'b0;
  endtask

  // scoreboard: consume exp_q, checking every cycle of every bit of every frame
  task automatic check_frames(input logic ready_after);
    logic [7:0] b;
    logic [9:0] frame;
    while (exp_q.size() > 0) begin
      b     = exp_q.pop_front();
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
        for (int c = 0; c < DIV; c++) begin
          chk($sformatf("txd_byte%02h_bit%0d", b, i), {31'h0, io_txd}, {31'h0, frame[i]});
          chk("busy_in_frame", {31'h0, io_busy}, 32'h1);
          chk("ready_in_frame", {31'h0, io_req_ready}, 32'h0);
          step();
        end
      end
    end
    chk("ready_after_frames", {31'h0, io_req_ready}, {31'h0, ready_after});
    chk("busy_after_frames", {31'h0, io_busy}, 32'h0);
    chk("txd_after_frames", {31'h0, io_txd}, 32'h1);
  endtask

  initial begin
    reset        = 1'b1;
    io_req_valid = 1'b0;
    io_req_code  = 8'h00;
    io_req_arg   = 32'h0;
    step(); step(); step();
    reset = 1'b0;

    // reset state
    chk("rst_txd", {31'h0, io_txd}, 32'h1);
    chk("rst_ready", {31'h0, io_req_ready}, 32'h1);
    chk("rst_busy", {31'h0, io_busy}, 32'h0);
    chk("rst_exit", {31'h0, io_exit}, 32'h0);
    chk("rst_exit_code", io_exit_code, 32'h0);
    chk("rst_state", {30'h0, io_dbg_state}, 32'h0);

    // print char 'A': 0,1,0,0,0,0,0,1,0,1
    send(8'h03, 32'h0000_0041);
    exp_q.push_back(8'h41);
    check_frames(1'b1);

    // unknown code dropped, then print char on the very next edge
    io_req_valid = 1'b1;
    io_req_code  = 8'h02;
    io_req_arg   = 32'hDEAD_BEEF;
    step();
    chk("unk_ready", {31'h0, io_req_ready}, 32'h1);
    chk("unk_busy", {31'h0, io_busy}, 32'h0);
    chk("unk_txd", {31'h0, io_txd}, 32'h1);
    io_req_code = 8'h03;
    io_req_arg  = 32'h0000_005A;
    step();
    io_req_valid = 1'b0;
    exp_q.push_back(8'h5A);
    check_frames(1'b1);

    // print float 1.5
    send(8'h04, 32'h3FC0_0000);
    exp_q.push_back(8'hF4);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'h3F);
    check_frames(1'b1);
    chk("float_no_exit", {31'h0, io_exit}, 32'h0);
    chk("float_exit_code", io_exit_code, 32'h0);

    // valid held through busy with the payload changed after accept
    io_req_valid = 1'b1;
    io_req_code  = 8'h03;
    io_req_arg   = 32'h0000_0031;
    step();
    io_req_arg   = 32'h0000_0032;
    exp_q.push_back(8'h31);
    check_frames(1'b1);
    step();
    io_req_valid = 1'b0;
    exp_q.push_back(8'h32);
    check_frames(1'b1);

    // reset mid-request, then a fresh print char
    send(8'h04, 32'h1234_5678);
    for (int k = 1; k < 300; k++) step();
    chk("mid_busy_before_rst", {31'h0, io_busy}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_txd", {31'h0, io_txd}, 32'h1);
    chk("midrst_busy", {31'h0, io_busy}, 32'h0);
    chk("midrst_ready", {31'h0, io_req_ready}, 32'h1);
    chk("midrst_state", {30'h0, io_dbg_state}, 32'h0);
    send(8'h03, 32'h0000_007E);
    exp_q.push_back(8'h7E);
    check_frames(1'b1);

    // exit with code 7
    send(8'h01, 32'h0000_0007);
    chk("exit_code_at_accept", io_exit_code, 32'h7);
    chk("exit_not_yet", {31'h0, io_exit}, 32'h0);
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    check_frames(1'b0);
    chk("exit_set", {31'h0, io_exit}, 32'h1);
    chk("exit_code_held", io_exit_code, 32'h7);

    // requests after exit are never accepted
    io_req_valid = 1'b1;
    io_req_code  = 8'h03;
    io_req_arg   = 32'h0000_0055;
    for (int k = 0; k < 3 * DIV; k++) begin
      step();
      chk("post_exit_ready", {31'h0, io_req_ready}, 32'h0);
      chk("post_exit_txd", {31'h0, io_txd}, 32'h1);
      chk("post_exit_busy", {31'h0, io_busy}, 32'h0);
    end
    io_req_valid = 1'b0;
    chk("post_exit_sticky", {31'h0, io_exit}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
